// File: rtl/kbd_pkg.sv
// Shared constants and types for the Kestrel-2 PS/2 keyboard port.
package kbd_pkg;

  // Bit positions inside the CPU-visible status/data word.
  localparam int KBD_VALID = 15;
  localparam int KBD_OVR   = 14;
  localparam int KBD_ERR   = 13;

  // Start + 8 data + parity + stop.
  localparam int PS2_FRAME_BITS = 11;

  // Receiver state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_t;

endpackage : kbd_pkg

// File: rtl/kbd_ps2io_line_filter.sv
// PS/2 line conditioner: 2-flop synchroniser, FILTER_LEN-sample debounce,
// and a one-cycle pulse on each filtered 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_filt,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    r_sync;
  logic          r_filt;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Synchronise the pin and accept a new level only after FILTER_LEN agreeing samples.
  // NOTE: every register here is updated with <= so all of them see the pre-edge
  // values of each other; blocking assignments would turn r_sync into a single flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
      r_filt <= 1'b1;
      r_fall <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_fall <= 1'b0;
      if (r_sync[1] != r_filt) begin
        if (r_cnt == CW'(FILTER_LEN - 1)) begin
          r_filt <= r_sync[1];
          r_fall <= r_filt;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_filt = r_filt;
  assign o_fall = r_fall;

endmodule : ps2_line_filter

// File: rtl/kbd_ps2io.sv
// PS/2 keyboard receiver with scan-code FIFO, served to the J1A as a
// one-wait-state cyc/stb/ack data-bus slave.
module kbd_ps2io
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        ps2c_i,
  input  logic        ps2d_i,
  input  logic [15:0] dat_dat_i,
  output logic [15:0] dat_dat_o,
  input  logic        dat_we_i,
  input  logic        dat_cyc_i,
  input  logic        dat_stb_i,
  output logic        dat_ack_o,
  output logic        kbd_rdy_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LAST_BIT = PS2_FRAME_BITS - 2;

  // ---------------------------------------------------------------- line conditioning
  logic w_ps2c_filt, w_ps2c_fall;
  logic w_ps2d_filt, w_ps2d_fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_clk (
    .i_clk  (sys_clk_i),
    .i_rst_n(sys_rst_i),
    .i_line (ps2c_i),
    .o_filt (w_ps2c_filt),
    .o_fall (w_ps2c_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_dat (
    .i_clk  (sys_clk_i),
    .i_rst_n(sys_rst_i),
    .i_line (ps2d_i),
    .o_filt (w_ps2d_filt),
    .o_fall (w_ps2d_fall)
  );

  // ---------------------------------------------------------------- receiver FSM
  rx_state_t       r_state;
  logic [3:0]      r_bitcnt;
  logic [9:0]      r_shift;     // {stop, parity, data[7:0]} once complete
  logic [TO_W-1:0] r_to_cnt;
  logic            r_push_req;  // one-cycle: good byte ready in r_byte
  logic [7:0]      r_byte;
  logic            r_err_evt;   // one-cycle: bad frame or timeout

  // Deframe start/data/parity/stop, validate in CHECK and abort stalled frames.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_to_cnt   <= '0;
      r_push_req <= 1'b0;
      r_byte     <= '0;
      r_err_evt  <= 1'b0;
    end else begin
      r_push_req <= 1'b0;
      r_err_evt  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ps2c_fall && !w_ps2d_filt) begin
            r_state  <= ST_RECV;
            r_bitcnt <= '0;
            r_to_cnt <= '0;
          end
        end
        ST_RECV: begin
          if (w_ps2c_fall) begin
            r_shift  <= {w_ps2d_filt, r_shift[9:1]};
            r_to_cnt <= '0;
            if (r_bitcnt == 4'(LAST_BIT)) r_state <= ST_CHECK;
            else r_bitcnt <= r_bitcnt + 4'd1;
          end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            r_err_evt <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        ST_CHECK: begin
          // Odd parity over data+parity, and the stop bit must be high.
          if ((^r_shift[8:0]) && r_shift[9]) begin
            r_push_req <= 1'b1;
            r_byte     <= r_shift[7:0];
          end else begin
            r_err_evt <= 1'b1;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- bus decode
  logic r_ack;
  logic w_req, w_rd, w_wr;

  assign w_req = dat_cyc_i & dat_stb_i & ~r_ack;
  assign w_rd  = w_req & ~dat_we_i;
  assign w_wr  = w_req & dat_we_i;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             w_empty, w_full, w_pop, w_push, w_ovr_set;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = w_rd & ~w_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte.
  assign w_push    = r_push_req & (~w_full | w_pop);
  assign w_ovr_set = r_push_req & w_full & ~w_pop;

  // Next occupancy from this cycle's push/pop pair.
  // NOTE: w_count_nxt gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + CNT_W'(1);
    else if (!w_push && w_pop) w_count_nxt = r_count - CNT_W'(1);
  end

  // Scan-code storage.
  // NOTE: the array has no reset; contents are only visible through r_count,
  // which is reset, and leaving it out lets the storage map to plain RAM.
  always_ff @(posedge sys_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= r_byte;
  end

  // Pointers, occupancy and the registered ready level.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      kbd_rdy_o <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count   <= w_count_nxt;
      kbd_rdy_o <= (w_count_nxt != '0);
    end
  end

  // ---------------------------------------------------------------- flags & bus
  logic r_ovr, r_err;
  logic [15:0] r_dat;

  // Sticky error flags; a set on the same edge as a write-clear wins.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_ovr <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ovr <= w_ovr_set | (r_ovr & ~(w_wr & dat_dat_i[KBD_OVR]));
      r_err <= r_err_evt | (r_err & ~(w_wr & dat_dat_i[KBD_ERR]));
    end
  end

  // One-wait-state ack; a read latches the status word and pops on the same edge.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req;
      if (w_rd) begin
        r_dat            <= '0;
        r_dat[KBD_VALID] <= ~w_empty;
        r_dat[KBD_OVR]   <= r_ovr;
        r_dat[KBD_ERR]   <= r_err;
        r_dat[7:0]       <= w_empty ? 8'h00 : r_mem[r_rd_ptr];
      end
    end
  end

  assign dat_ack_o = r_ack;
  assign dat_dat_o = r_dat;

  // Write data bits other than the flag clears, and the unused filter outputs.
  logic w_unused;
  assign w_unused = ^{dat_dat_i[15], dat_dat_i[12:0], w_ps2c_filt, w_ps2d_fall};

endmodule : kbd_ps2io

// File: tb/tb_kbd_ps2io.sv
// Self-checking bench for kbd_ps2io: randomised PS/2 frames and bus accesses
// against a queue-based reference model, with a scoreboard monitor on dat_ack_o.
module tb_kbd_ps2io;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2c = 1'b1;
  logic        ps2d = 1'b1;
  logic [15:0] dat_i = '0;
  logic [15:0] dat_o;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic        ack, rdy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kbd_ps2io dut (
    .sys_clk_i(clk),
    .sys_rst_i(rst_n),
    .ps2c_i   (ps2c),
    .ps2d_i   (ps2d),
    .dat_dat_i(dat_i),
    .dat_dat_o(dat_o),
    .dat_we_i (we),
    .dat_cyc_i(cyc),
    .dat_stb_i(stb),
    .dat_ack_o(ack),
    .kbd_rdy_o(rdy)
  );

  // ------------------------------------------------------------ reference model
  byte unsigned byte_q[$];
  bit m_ovr = 0, m_err = 0;

  typedef struct {
    bit          chk;
    logic [15:0] w;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read();
    logic [15:0] w;
    w = {1'b0, m_ovr, m_err, 13'd0};
    if (byte_q.size() != 0) begin
      w[15]  = 1'b1;
      w[7:0] = byte_q.pop_front();
    end
    return w;
  endfunction

  // Scoreboard monitor: every ack consumes one expected entry.
  always @(negedge clk) begin
    if (rst_n && ack) begin
      if (sb_q.size() == 0) check("unexpected_ack", ack, 1'b0);
      else begin
        mon_e = sb_q.pop_front();
        if (mon_e.chk) check("rd_word", dat_o, mon_e.w);
      end
    end
  end

  // ------------------------------------------------------------ stimulus helpers
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_xfer(input logic w, input logic [15:0] d);
    wait_cyc(1);
    cyc = 1'b1; stb = 1'b1; we = w; dat_i = d;
    check("ack_pre", ack, 1'b0);
    wait_cyc(1);
    check("ack_hi", ack, 1'b1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    wait_cyc(1);
    check("ack_lo", ack, 1'b0);
  endtask

  task automatic bus_read();
    exp_t e;
    e.chk = 1'b1;
    e.w   = model_read();
    sb_q.push_back(e);
    do_xfer(1'b0, 16'h0000);
    check("rdy_after_rd", rdy, byte_q.size() != 0);
  endtask

  task automatic bus_write(input logic [15:0] d);
    exp_t e;
    e.chk = 1'b0;
    e.w   = '0;
    sb_q.push_back(e);
    if (d[14]) m_ovr = 0;
    if (d[13]) m_err = 0;
    do_xfer(1'b1, d);
  endtask

  // Drives n bits LSB first; optional 3-cycle clock glitch in the high phase before bit glitch_bit.
  task automatic ps2_bits(input logic [10:0] bits, input int n, input int h, input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      ps2d = bits[i];
      if (i == glitch_bit) begin
        wait_cyc(12); ps2c = 1'b0;
        wait_cyc(3);  ps2c = 1'b1;
        wait_cyc(h - 15);
      end else begin
        wait_cyc(h);
      end
      ps2c = 1'b0;
      wait_cyc(h);
      ps2c = 1'b1;
    end
    wait_cyc(h);
    ps2d = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int h, input int glitch_bit);
    ps2_bits(frame_bits(b, bad_par), 11, h, glitch_bit);
    wait_cyc(30);
    if (bad_par) m_err = 1;
    else if (byte_q.size() < 8) byte_q.push_back(b);
    else m_ovr = 1;
    check("rdy_after_frame", rdy, byte_q.size() != 0);
  endtask

  // ------------------------------------------------------------ test sequence
  initial begin
    int r;
    exp_t e;

    // Reset state
    wait_cyc(3);
    check("rst_ack", ack, 1'b0);
    check("rst_dat", dat_o, 16'h0000);
    check("rst_rdy", rdy, 1'b0);
    rst_n = 1'b1;
    wait_cyc(5);

    // Good frame, then a read and an empty read
    send_frame(8'h1C, 0, 16, -1);
    bus_read();
    bus_read();

    // Parity error sets err; write clears it
    send_frame(8'h1C, 1, 16, -1);
    bus_read();
    bus_write(16'h2000);
    bus_read();

    // Nine frames into an 8-deep FIFO -> overrun
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 14, -1);
    for (int i = 0; i < 9; i++) bus_read();
    bus_write(16'h4000);
    bus_read();

    // Partial frame times out, then a good frame
    ps2_bits(frame_bits(8'hF0, 0), 5, 14, -1);
    wait_cyc(50100);
    m_err = 1;
    send_frame(8'hF0, 0, 14, -1);
    bus_read();
    bus_write(16'h2000);

    // Clock glitches while idle and mid-frame are ignored
    ps2c = 1'b0; wait_cyc(3); ps2c = 1'b1;
    wait_cyc(20);
    send_frame(8'h5A, 0, 24, 5);
    bus_read();

    // Held strobe: ack on every other cycle
    for (int k = 0; k < 2; k++) begin
      e.chk = 1'b1;
      e.w   = model_read();
      sb_q.push_back(e);
    end
    wait_cyc(1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    wait_cyc(1); check("b2b_ack0", ack, 1'b1);
    wait_cyc(1); check("b2b_ack1", ack, 1'b0);
    wait_cyc(1); check("b2b_ack2", ack, 1'b1);
    cyc = 1'b0; stb = 1'b0;
    wait_cyc(1); check("b2b_ack3", ack, 1'b0);

    // Reset mid-frame discards FIFO contents and the partial frame
    send_frame(8'h33, 0, 14, -1);
    ps2_bits(frame_bits(8'h29, 0), 5, 14, -1);
    rst_n = 1'b0;
    wait_cyc(2);
    check("midrst_ack", ack, 1'b0);
    check("midrst_dat", dat_o, 16'h0000);
    check("midrst_rdy", rdy, 1'b0);
    byte_q.delete();
    m_ovr = 0; m_err = 0;
    rst_n = 1'b1;
    wait_cyc(5);
    send_frame(8'h29, 0, 14, -1);
    bus_read();

    // Randomised mix of frames, reads and writes
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 4)      send_frame(8'($urandom_range(0, 255)), 0, int'($urandom_range(14, 18)), -1);
      else if (r == 5) send_frame(8'($urandom_range(0, 255)), 1, int'($urandom_range(14, 18)), -1);
      else if (r <= 8) bus_read();
      else             bus_write(16'($urandom_range(0, 65535)));
    end
    while (byte_q.size() != 0) bus_read();
    bus_read();

    wait_cyc(3);
    check("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_kbd_ps2io

// File: doc/kbd_ps2io.md
Name: kbd_ps2io

Overview:
PS/2 keyboard receiver and CPU-facing data port for the Kestrel-2, decoded at $FFFE on the J1A data bus.
- Samples the keyboard clock and data lines.
- Deframes 11-bit PS/2 frames and checks parity and stop bit.
- Queues scan codes in a small FIFO.
- Serves them to the J1A over the same cyc/stb/ack/we data-bus protocol as program and video memory.
- Top level adds `addressing_kbd_ps2` decode and muxes `dat_dat_o` into the CPU read bus.

Parameters:
- FIFO_DEPTH, 8, scan-code FIFO entries; power of two, 2..16.
- FILTER_LEN, 8, consecutive identical sys_clk samples required before a filtered PS/2 line changes.
- TIMEOUT_CYCLES, 50000, sys_clk cycles without a PS/2 falling edge that abort a partial frame (2 ms at 25 MHz).

Ports:
- sys_clk_i  in  1  system clock (25 MHz from MGIA).
- sys_rst_i  in  1  reset; asynchronous, active-low.
- ps2c_i  in  1  raw PS/2 clock pin.
- ps2d_i  in  1  raw PS/2 data pin.
- dat_dat_i  in  16  CPU write data.
- dat_dat_o  out  16  status/data word.
- dat_we_i  in  1  write enable.
- dat_cyc_i  in  1  bus cycle.
- dat_stb_i  in  1  decoded strobe for this device.
- dat_ack_o  out  1  acknowledge.
- kbd_rdy_o  out  1  FIFO non-empty (level).

Behaviour:
- Reset (sys_rst_i=0, asynchronous):
  - dat_ack_o=0, dat_dat_o=0, kbd_rdy_o=0.
  - FIFO empty; overrun and error flags 0.
  - Receiver in IDLE; filters preset to 1.
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - Each line passes a 2-flop synchroniser, then the filter.
  - Filtered output toggles only after FILTER_LEN identical synchronised samples.
  - fall = filtered ps2c 1->0, one-cycle pulse.
- Receiver FSM:
  - IDLE: on fall with data=0, go to RECV with bitcnt=0. On fall with data=1, stay in IDLE.
  - RECV: on each fall, shift data in LSB-first and increment bitcnt. After 10 bits (8 data, parity, stop), go to CHECK.
  - RECV timeout: counter clears on every fall. When it reaches TIMEOUT_CYCLES, set err and return to IDLE.
  - CHECK, one cycle: frame is good if data+parity has odd weight AND stop=1.
    - Good: push byte if not full; if full, drop byte and set ovr.
    - Bad: discard byte and set err.
    - Return to IDLE.
- Status word (dat_dat_o, registered on the ack cycle):
  - [15] valid (FIFO non-empty at read).
  - [14] ovr.
  - [13] err.
  - [12:8] 0.
  - [7:0] head byte if valid, else 0x00.
- Bus handshake:
  - Request = dat_cyc_i & dat_stb_i & ~dat_ack_o.
  - dat_ack_o is asserted the cycle after a request, for exactly one cycle (one-wait-state, as for memory).
  - Back-to-back strobes therefore ack every other cycle.
- Read (we=0):
  - On the ack cycle, dat_dat_o holds the sampled word.
  - If valid, the FIFO pops on that same edge.
  - Flags are not cleared by reads.
- Write (we=1):
  - dat_dat_i[14]=1 clears ovr; dat_dat_i[13]=1 clears err. Other bits ignored.
  - Ack follows the same timing as a read; no pop.
- Simultaneous events:
  - Push and pop on the same edge: both occur, count unchanged.
  - Push to a full FIFO on the same edge as a pop: accepted, not an overrun.
  - Flag set and write-clear on the same edge: set wins.
- kbd_rdy_o = registered (count != 0).
- Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package kbd_pkg:
  - Status bit positions (KBD_VALID=15, KBD_OVR=14, KBD_ERR=13).
  - PS2_FRAME_BITS=11.
  - Receiver state encoding (IDLE, RECV, CHECK).
- Sub-module ps2_line_filter (synchroniser + FILTER_LEN debounce + falling-edge pulse), instantiated once per PS/2 line.
- FIFO, FSM and bus logic are inline.

Test Plan:
- Frame 0x1C (parity 0, stop 1) at 12.5 kHz, then two reads -> first read returns 0x801C with kbd_rdy_o falling after the pop; second read returns 0x0000; dat_ack_o is a one-cycle pulse one cycle after stb.
- Frame 0x1C with parity=1 -> no push; read returns 0x2000; write 0x2000, then read -> 0x0000.
- Nine good frames 0x01..0x09 with no reads -> first read 0xC001; next seven reads 0xC002..0xC008; ninth read 0x4000; write 0x4000 clears ovr.
- Start bit plus 4 bits, then 50000 idle cycles, then good frame 0xF0 (parity 1) -> read returns 0xA0F0.
- 3-cycle low glitch on ps2c_i while IDLE and mid-frame -> ignored; a subsequent frame 0x5A decodes as 0x805A.
- Assert sys_rst_i=0 after 5 bits of a frame, then release and send 0x29 -> all outputs 0 during reset; read then returns 0x8029 with no err.
